// File: rtl/ifmap_fetch_ctrl_if.sv
// ifmap_fetch_ctrl_if: tile start/config, ifmap ROM port and output beat stream of ifmap_fetch_ctrl.
interface ifmap_fetch_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DIM_W  = 8
);
  logic              start;
  logic [ADDR_W-1:0] cfg_base;
  logic [DIM_W-1:0]  cfg_cols;
  logic [DIM_W-1:0]  cfg_rows;
  logic [ADDR_W-1:0] cfg_stride;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_row_end;
  logic              out_last;
  logic              busy;
  logic              done;
  modport master (
    input  start, cfg_base, cfg_cols, cfg_rows, cfg_stride, rom_data, out_ready,
    output rom_addr, out_data, out_valid, out_row_end, out_last, busy, done
  );
  modport slave (
    output start, cfg_base, cfg_cols, cfg_rows, cfg_stride, rom_data, out_ready,
    input  rom_addr, out_data, out_valid, out_row_end, out_last, busy, done
  );
endinterface

// File: rtl/ifmap_fetch_ctrl.sv
// ifmap_fetch_ctrl: walks a rows x cols ifmap tile through the ROM and streams the data out.
// Defining IFMAP_FETCH_PERF_EN adds stall_cnt_o, a saturating count of stalled valid cycles.
module ifmap_fetch_ctrl #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int DIM_W     = 8,
  parameter int BUF_DEPTH = 2
) (
  input logic clk,
  input logic rst,
  ifmap_fetch_ctrl_if.master bus
`ifdef IFMAP_FETCH_PERF_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [DIM_W-1:0] cols_q, rows_q, col_q, row_q;
  logic [ADDR_W-1:0] stride_q, row_base_q, addr_q, next_row_base;
  logic infl_q, infl_re_q, infl_last_q;
  logic [DATA_W+1:0] buf_q [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] occ_q;
  logic accept, empty_cfg, pop, last_col, last_row, issue, tile_end, drained;
  function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
    return p == PTR_W'(BUF_DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction
  // addr_q is the candidate address the ROM is always reading; it counts as issued only
  // when the credit check passes at the end of the cycle, otherwise it is simply re-read.
  always_comb begin
    accept        = state_q == IDLE && bus.start;
    empty_cfg     = bus.cfg_rows == '0 || bus.cfg_cols == '0;
    pop           = occ_q != '0 && bus.out_ready;
    last_col      = col_q == cols_q - DIM_W'(1);
    last_row      = row_q == rows_q - DIM_W'(1);
    issue         = state_q == FETCH && int'(occ_q) + int'(infl_q) - int'(pop) < BUF_DEPTH;
    tile_end      = issue && last_col && last_row;
    drained       = !infl_q && occ_q == OCC_W'(pop);
    next_row_base = row_base_q + stride_q;
  end
  always_comb begin
    state_d = state_q;
    state_d = state_q == IDLE  ? (bus.start ? (empty_cfg ? DONE : FETCH) : IDLE) :
              state_q == FETCH ? (tile_end ? DRAIN : FETCH) :
              state_q == DRAIN ? (drained ? DONE : DRAIN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cols_q      <= '0;
      rows_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      stride_q    <= '0;
      row_base_q  <= '0;
      addr_q      <= '0;
      infl_q      <= 1'b0;
      infl_re_q   <= 1'b0;
      infl_last_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cols_q     <= bus.cfg_cols;
        rows_q     <= bus.cfg_rows;
        stride_q   <= bus.cfg_stride;
        row_base_q <= bus.cfg_base;
        addr_q     <= bus.cfg_base;
        col_q      <= '0;
        row_q      <= '0;
      end else if (issue && !tile_end) begin
        col_q      <= last_col ? '0 : col_q + DIM_W'(1);
        row_q      <= last_col ? row_q + DIM_W'(1) : row_q;
        row_base_q <= last_col ? next_row_base : row_base_q;
        addr_q     <= last_col ? next_row_base : addr_q + ADDR_W'(1);
      end
      infl_q      <= issue;
      infl_re_q   <= last_col;
      infl_last_q <= tile_end;
      if (infl_q) buf_q[wr_ptr_q] <= {infl_last_q, infl_re_q, bus.rom_data};
      if (infl_q) wr_ptr_q <= inc(wr_ptr_q);
      if (pop) rd_ptr_q <= inc(rd_ptr_q);
      occ_q <= occ_q + OCC_W'(infl_q) - OCC_W'(pop);
    end
  end
  assign bus.rom_addr    = addr_q;
  assign bus.out_valid   = occ_q != '0;
  assign bus.out_data    = buf_q[rd_ptr_q][DATA_W-1:0];
  assign bus.out_row_end = bus.out_valid && buf_q[rd_ptr_q][DATA_W];
  assign bus.out_last    = bus.out_valid && buf_q[rd_ptr_q][DATA_W+1];
  assign bus.busy        = state_q != IDLE;
  assign bus.done        = state_q == DONE;
`ifdef IFMAP_FETCH_PERF_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk) begin
    if (rst || accept) stall_q <= '0;
    else if (bus.out_valid && !bus.out_ready && state_q != IDLE && stall_q != '1) stall_q <= stall_q + 32'd1;
  end
  assign stall_cnt_o = stall_q;
`endif
endmodule
